nf10_oq_pkt_fifo: RTL
=====================

NF10_OQ_PKT_FIFO -- requirements
Module: nf10_oq_pkt_fifo

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, tdata width of both streams.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, tuser width of both streams.
REQ-003 SHALL have parameter C_DEPTH_LOG2, default 9, log2 of buffer depth in beats (512).
REQ-004 SHALL have port aclk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports s_axis_tdata in 256, s_axis_tstrb in 32, s_axis_tuser in 128, s_axis_tvalid in 1, s_axis_tlast in 1: ingress packet stream from the output-queue arbiter.
REQ-007 SHALL have port s_axis_tready  out  1  ingress ready, always 1 out of reset (no backpressure).
REQ-008 SHALL have ports m_axis_tdata out 256, m_axis_tstrb out 32, m_axis_tuser out 128, m_axis_tvalid out 1, m_axis_tlast out 1: egress stream to DMA port 4 / stream recorder.
REQ-009 SHALL have port m_axis_tready  in  1  egress ready.
REQ-010 SHALL have ports pkt_stored_cnt out 32 and pkt_dropped_cnt out 32 (present only per REQ-030).

Function
REQ-011 SHALL buffer tdata, tstrb, tuser and tlast of every accepted beat in one (DATA+STRB+TUSER+1)-bit x 2^C_DEPTH_LOG2 memory.
REQ-012 SHALL operate store-and-forward: no beat of a packet presented on m_axis before its tlast beat is committed.
REQ-013 SHALL implement write FSM W_IDLE, W_PKT, W_DROP; reset state W_IDLE.
REQ-014 W_IDLE: on accepted beat with free space -> write, latch pkt_start = wr_ptr; tlast=1 commits and stays W_IDLE, else -> W_PKT.
REQ-015 W_PKT: each accepted beat written; tlast beat commits (committed_wr_ptr = wr_ptr+1) -> W_IDLE.
REQ-016 Full (wr_ptr+1 == rd_ptr mod depth) on an accepted beat in W_IDLE/W_PKT: beat discarded, wr_ptr restored to pkt_start, -> W_DROP; if that beat has tlast, -> W_IDLE instead.
REQ-017 W_DROP: all beats discarded; tlast beat -> W_IDLE; pkt_dropped_cnt +1 once per dropped packet.
REQ-018 Pointers C_DEPTH_LOG2 bits, wrap modulo depth; one slot always unused to distinguish full/empty.
REQ-019 SHALL keep committed packet count pkt_q (C_DEPTH_LOG2+1 bits): +1 on commit, -1 on egress tlast handshake, unchanged when both occur same cycle.
REQ-020 Egress read uses registered memory output; m_axis_tvalid SHALL rise 2 cycles after the commit edge (tlast accepted at edge k -> tvalid high after edge k+2) when buffer was empty.
REQ-021 m_axis_tvalid high iff output register holds a beat of a committed packet; m_axis_* stable while tvalid=1 and tready=0.
REQ-022 With tready held 1, consecutive committed beats SHALL stream one per cycle, including back-to-back packets without bubble.
REQ-023 Egress read pointer only ever reads up to committed_wr_ptr; uncommitted or rolled-back beats never emitted.
REQ-024 Simultaneous ingress write and egress read in the same cycle SHALL both proceed.

Reset
REQ-025 On aresetn=0 (asynchronous): pointers, pkt_q, FSM -> 0/W_IDLE; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tstrb/tuser=0, s_axis_tready=0.
REQ-026 s_axis_tready SHALL go 1 on the first edge after aresetn deasserts.
REQ-027 Reset mid-packet SHALL discard all buffered and partial packets; no stale beat emitted after reset.
REQ-028 Memory contents need not be reset.
REQ-029 Counters reset to 0 (when present).

Configuration
REQ-030 Macro NF10_OQ_PKT_STATS_EN defined: pkt_stored_cnt (+1 per commit) and pkt_dropped_cnt (+1 per drop) present, 32-bit saturating; undefined: both ports and counters absent, datapath identical.

Verification
REQ-031 Single 1-beat packet (tlast=1, tuser=0x40) at edge 10, tready=1 -> m_axis_tvalid high after edge 12, same data/tuser, tlast=1.
REQ-032 Four back-to-back 8-beat packets, tready=1 -> 32 consecutive egress beats, no bubble, pkt_stored_cnt=4.
REQ-033 tready=0, ingress 600-beat packet (depth 512) -> packet dropped, no egress, pkt_dropped_cnt=1; following 4-beat packet stored and emitted intact.
REQ-034 Egress stall: tready toggled 1/0 each cycle over a 16-beat packet -> 16 beats in order, held stable during stalls.
REQ-035 aresetn pulsed low mid-packet (beat 3 of 8) with one committed packet queued -> tvalid=0 immediately, no beats emitted after reset until new packet committed.
REQ-036 Pointer wrap: 100 x 7-beat packets with tready=1 -> all 700 beats emitted in order, pkt_dropped_cnt=0.

Source files
------------

// File: rtl/nf10_oq_pkt_fifo_if.sv
// AXI4-Stream bundle for the output-queue packet FIFO; master drives data/valid/last, slave drives ready.
interface nf10_oq_pkt_fifo_if #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
);
  logic [C_S_AXIS_DATA_WIDTH-1:0]   tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] tstrb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  tuser;
  logic                             tvalid;
  logic                             tready;
  logic                             tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_oq_pkt_fifo.sv
// Store-and-forward packet FIFO: egress valid 2 cycles after tlast commit; ingress never backpressures,
// packets that overflow are dropped whole. Define NF10_OQ_PKT_STATS_EN for stored/dropped packet counters.
module nf10_oq_pkt_fifo #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH_LOG2         = 9
) (
  input  logic               aclk,
  input  logic               aresetn,
  nf10_oq_pkt_fifo_if.slave  s_axis,
  nf10_oq_pkt_fifo_if.master m_axis
`ifdef NF10_OQ_PKT_STATS_EN
  ,
  output logic [31:0]        pkt_stored_cnt,
  output logic [31:0]        pkt_dropped_cnt
`endif
);
  localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int BEAT_W = C_S_AXIS_DATA_WIDTH + STRB_W + C_S_AXIS_TUSER_WIDTH + 1;
  localparam int DEPTH  = 1 << C_DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wr_state_t;

  wr_state_t               wr_state;
  logic [BEAT_W-1:0]       mem [DEPTH];
  logic [BEAT_W-1:0]       wr_beat;
  logic [BEAT_W-1:0]       rd_beat;
  logic [BEAT_W-1:0]       out_beat;
  logic [C_DEPTH_LOG2-1:0] wr_ptr;
  logic [C_DEPTH_LOG2-1:0] wr_ptr_nxt;
  logic [C_DEPTH_LOG2-1:0] pkt_start;
  logic [C_DEPTH_LOG2-1:0] committed_wr_ptr;
  logic [C_DEPTH_LOG2-1:0] rd_ptr;
  logic [C_DEPTH_LOG2:0]   pkt_q;
  logic                    s_rdy;
  logic                    rd_vld;
  logic                    out_vld;
  logic                    accept;
  logic                    full;
  logic                    wr_en;
  logic                    commit;
  logic                    drop;
  logic                    rd_move;
  logic                    fetch;
  logic                    egress_last;

  assign wr_beat    = {s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata};
  assign wr_ptr_nxt = wr_ptr + C_DEPTH_LOG2'(1);
  assign accept     = s_axis.tvalid && s_rdy;
  assign full       = (wr_ptr_nxt == rd_ptr);
  assign wr_en      = accept && !full && (wr_state != W_DROP);
  assign commit     = wr_en && s_axis.tlast;
  assign drop       = accept && full && (wr_state != W_DROP);

  // Two-stage read: memory output register feeds the egress register, so a stalled
  // egress still lets the next beat be prefetched and tready=1 streams one beat per cycle.
  assign egress_last = out_vld && m_axis.tready && out_beat[BEAT_W-1];
  assign rd_move     = rd_vld && (!out_vld || m_axis.tready);
  assign fetch       = (rd_ptr != committed_wr_ptr) && (pkt_q != '0) && (!rd_vld || rd_move);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state         <= W_IDLE;
      wr_ptr           <= '0;
      pkt_start        <= '0;
      committed_wr_ptr <= '0;
      s_rdy            <= 1'b0;
    end else begin
      s_rdy <= 1'b1;
      if (commit) committed_wr_ptr <= wr_ptr_nxt;
      case (wr_state)
        W_IDLE: begin
          if (wr_en) begin
            wr_ptr    <= wr_ptr_nxt;
            pkt_start <= wr_ptr;
            if (!s_axis.tlast) wr_state <= W_PKT;
          end else if (drop && !s_axis.tlast) begin
            wr_state <= W_DROP;
          end
        end
        W_PKT: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr_nxt;
            if (s_axis.tlast) wr_state <= W_IDLE;
          end else if (drop) begin
            wr_ptr   <= pkt_start;
            wr_state <= s_axis.tlast ? W_IDLE : W_DROP;
          end
        end
        W_DROP: begin
          if (accept && s_axis.tlast) wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Only committed slots are fetched and wr_ptr is never committed, so read and write never collide.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr] <= wr_beat;
    if (fetch) rd_beat <= mem[rd_ptr];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr   <= '0;
      rd_vld   <= 1'b0;
      out_vld  <= 1'b0;
      out_beat <= '0;
      pkt_q    <= '0;
    end else begin
      if (fetch) begin
        rd_ptr <= rd_ptr + C_DEPTH_LOG2'(1);
        rd_vld <= 1'b1;
      end else if (rd_move) begin
        rd_vld <= 1'b0;
      end
      if (rd_move) begin
        out_vld  <= 1'b1;
        out_beat <= rd_beat;
      end else if (m_axis.tready) begin
        out_vld <= 1'b0;
      end
      case ({commit, egress_last})
        2'b10:   pkt_q <= pkt_q + (C_DEPTH_LOG2+1)'(1);
        2'b01:   pkt_q <= pkt_q - (C_DEPTH_LOG2+1)'(1);
        default: pkt_q <= pkt_q;
      endcase
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = out_vld;
  assign {m_axis.tlast, m_axis.tuser, m_axis.tstrb, m_axis.tdata} = out_beat;

`ifdef NF10_OQ_PKT_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_stored_cnt  <= '0;
      pkt_dropped_cnt <= '0;
    end else begin
      if (commit && (pkt_stored_cnt != '1)) pkt_stored_cnt <= pkt_stored_cnt + 32'd1;
      if (drop && (pkt_dropped_cnt != '1)) pkt_dropped_cnt <= pkt_dropped_cnt + 32'd1;
    end
  end
`endif
endmodule
